tex_fetch_scheduler: RTL and testbench
======================================

TEX_FETCH_SCHEDULER -- requirements
Module: tex_fetch_scheduler

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width of texture requests and memory requests.
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 2, one per requester, asserting a texel fetch request.
REQ-005 The block SHALL have port req_ready, output, 2, one per requester, accepting the request this cycle.
REQ-006 The block SHALL have port req_addr, input, 2*ADDR_W, per-requester texel byte address; requester i uses slice [i*ADDR_W +: ADDR_W].
REQ-007 The block SHALL have ports req_format (input, 2*5), req_texelX (input, 2*2) and req_texelY (input, 2*2), giving per-requester texture format and in-block texel coordinates.
REQ-008 The block SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1) and mem_req_addr (output, ADDR_W), forming the memory read request handshake.
REQ-009 The block SHALL have ports mem_rsp_valid (input, 1) and mem_rsp_data (input, 128), carrying the memory read data beat.
REQ-010 The block SHALL have ports dec_data (output, 128), dec_format (output, 5), dec_texelX (output, 2) and dec_texelY (output, 2), driving the combinational color decoder.
REQ-011 The block SHALL have port dec_rgba, input, 32, carrying decoder output packed as {A,B,G,R}.
REQ-012 The block SHALL have ports rsp_valid (output, 2, one per requester), rsp_ready (input, 2), rsp_rgba (output, 32) and rsp_err (output, 1), forming the result handshake.
REQ-013 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 The block SHALL implement FSM states IDLE, MEM_REQ, MEM_WAIT, DECODE and RESP, with one request in flight at a time.
REQ-015 In IDLE with any req_valid high, the block SHALL grant exactly one requester: the round-robin pointer's requester if it is valid, otherwise the other requester.
REQ-016 On grant, req_ready of the winner SHALL be high for that single cycle, and the block SHALL latch the winner's addr, format, texelX, texelY and id.
REQ-017 After a grant, the round-robin pointer SHALL point to the non-winner.
REQ-018 req_ready SHALL be zero outside IDLE and at most one-hot.
REQ-019 After a grant, the next state SHALL be MEM_REQ, except when latched format[1:0]==2'b10 (compressed, unsupported), when it SHALL be RESP with rsp_rgba=32'h0 and rsp_err=1 and no memory access.
REQ-020 In MEM_REQ, mem_req_valid SHALL be 1 and mem_req_addr SHALL equal {addr[ADDR_W-1:4],4'b0000}, both held stable until mem_req_ready, after which the state SHALL be MEM_WAIT.
REQ-021 In MEM_WAIT, on mem_rsp_valid the block SHALL latch mem_rsp_data into the data register and go to DECODE.
REQ-022 mem_rsp_valid SHALL be ignored in every state other than MEM_WAIT.
REQ-023 dec_data, dec_format, dec_texelX and dec_texelY SHALL always be driven from the latched registers.
REQ-024 In DECODE, the block SHALL capture dec_rgba into rsp_rgba with rsp_err=0 at the end of the cycle and go to RESP.
REQ-025 In RESP, only rsp_valid[id] SHALL be high, and rsp_rgba/rsp_err SHALL be held stable until rsp_ready[id]=1, after which the state SHALL return to IDLE.
REQ-026 In RESP, rsp_ready of the non-owning requester SHALL be ignored.
REQ-027 A new grant SHALL be possible no earlier than the cycle after the RESP handshake.
REQ-028 Minimum latency from grant (cycle 0) to rsp_valid SHALL be 4 cycles, given mem_req_ready in cycle 1 and mem_rsp_valid in cycle 2.
REQ-029 Memory stalls SHALL extend MEM_REQ and MEM_WAIT without bound, with no timeout.

Reset
REQ-030 On rst_n low, asynchronously: state=IDLE, round-robin pointer=0, all latched registers=0, rsp_rgba=0, rsp_err=0; req_ready, mem_req_valid, rsp_valid and busy SHALL all be 0.
REQ-031 Reset mid-operation SHALL abandon the in-flight request, and a memory response arriving after reset deassertion SHALL be ignored.

Verification
REQ-032 Single request: req_valid=2'b01, addr=0x1234, format=5'b00100; mem_req_ready=1 immediately; rsp data[31:0]=0x80402010 one cycle later; dec_rgba follows data -> mem_req_addr=0x1230, rsp_valid=2'b01 at cycle 4, rsp_rgba=0x80402010, rsp_err=0.
REQ-033 Contention: both req_valid held high from reset for 4 transactions -> grants alternate 0,1,0,1, and req_ready is never 2'b11.
REQ-034 Compressed format: format=5'b00010 -> no mem_req_valid pulse, rsp_valid in the cycle after grant, rsp_rgba=0, rsp_err=1.
REQ-035 Backpressure: mem_req_ready low for 5 cycles, then rsp_ready low for 3 cycles -> mem_req_addr, rsp_rgba and rsp_valid stay stable throughout; a single transaction completes.
REQ-036 Stray response and reset: mem_rsp_valid pulsed in IDLE -> no state change; rst_n asserted in MEM_WAIT, then mem_rsp_valid after release -> busy=0 and no rsp_valid.

Source files
------------

// File: rtl/tex_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// tex_fetch_scheduler
//   Arbitrates texel fetch requests from two requesters (round-robin), issues
//   one 128-bit memory line read per request, feeds the returned line to an
//   external combinational color decoder and returns the decoded RGBA to the
//   owning requester. Only one request is in flight at a time.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]     per-requester request handshake
//   req_addr [2*ADDR_W-1:0]       per-requester texel byte address
//   req_format/texelX/texelY      per-requester format and in-block texel
//   mem_req_valid/ready/addr      memory line read request (16-byte aligned)
//   mem_rsp_valid/data            memory read data beat
//   dec_data/format/texelX/texelY latched inputs for the color decoder
//   dec_rgba                      decoder result {A,B,G,R}
//   rsp_valid/ready [1:0]         per-requester result handshake
//   rsp_rgba, rsp_err             result color and unsupported-format flag
//   busy                          high whenever a request is in flight
// ---------------------------------------------------------------------------
module tex_fetch_scheduler #(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [9:0]          req_format,
    input  logic [3:0]          req_texelX,
    input  logic [3:0]          req_texelY,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_rsp_valid,
    input  logic [127:0]        mem_rsp_data,
    output logic [127:0]        dec_data,
    output logic [4:0]          dec_format,
    output logic [1:0]          dec_texelX,
    output logic [1:0]          dec_texelY,
    input  logic [31:0]         dec_rgba,
    output logic [1:0]          rsp_valid,
    input  logic [1:0]          rsp_ready,
    output logic [31:0]         rsp_rgba,
    output logic                rsp_err,
    output logic                busy
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MEM_REQ  = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_DECODE   = 3'd3,
        ST_RESP     = 3'd4
    } state_e;

    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    state_e              state_q, state_d;
    logic                rr_q, rr_d;
    logic                id_q, id_d;
    // Only the line address is kept; the low nibble never leaves the block.
    logic [ADDR_W-5:0]   line_q, line_d;
    logic [4:0]          fmt_q, fmt_d;
    logic [1:0]          tx_q, tx_d;
    logic [1:0]          ty_q, ty_d;
    logic [127:0]        data_q, data_d;
    logic [31:0]         rgba_q, rgba_d;
    logic                err_q, err_d;
    logic                busy_q;
    logic                mem_req_valid_q;
    logic [1:0]          rsp_valid_q;

    logic                grant_s;
    logic                win_id_s;
    logic [ADDR_W-5:0]   win_line_s;
    logic [4:0]          win_fmt_s;
    logic [1:0]          win_tx_s;
    logic [1:0]          win_ty_s;

    assign grant_s = (state_q == ST_IDLE) && (req_valid != 2'b00);

    // Round-robin winner selection and mux of the winner's request fields.
    always_comb begin
        if (req_valid[rr_q]) begin
            win_id_s = rr_q;
        end else begin
            win_id_s = ~rr_q;
        end
        if (win_id_s) begin
            win_line_s = req_addr[2*ADDR_W-1:ADDR_W+4];
            win_fmt_s  = req_format[9:5];
            win_tx_s   = req_texelX[3:2];
            win_ty_s   = req_texelY[3:2];
        end else begin
            win_line_s = req_addr[ADDR_W-1:4];
            win_fmt_s  = req_format[4:0];
            win_tx_s   = req_texelX[1:0];
            win_ty_s   = req_texelY[1:0];
        end
    end

    // Grant pulse; must be combinational to complete the handshake in IDLE.
    always_comb begin
        if (rst_n && grant_s) begin
            req_ready = id_onehot(win_id_s);
        end else begin
            req_ready = 2'b00;
        end
    end

    // Next-state and datapath-register update logic.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        line_d  = line_q;
        fmt_d   = fmt_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        data_d  = data_q;
        rgba_d  = rgba_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_s) begin
                    id_d   = win_id_s;
                    line_d = win_line_s;
                    fmt_d  = win_fmt_s;
                    tx_d   = win_tx_s;
                    ty_d   = win_ty_s;
                    rr_d   = ~win_id_s;
                    // Compressed formats are unsupported: answer with an error
                    // straight away and never touch memory.
                    if (win_fmt_s[1:0] == 2'b10) begin
                        state_d = ST_RESP;
                        rgba_d  = 32'h0000_0000;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_MEM_REQ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MEM_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end else begin
                    state_d = ST_MEM_REQ;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_rsp_valid) begin
                    data_d  = mem_rsp_data;
                    state_d = ST_DECODE;
                end else begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_DECODE: begin
                rgba_d  = dec_rgba;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[id_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rr_q            <= 1'b0;
            id_q            <= 1'b0;
            line_q          <= '0;
            fmt_q           <= 5'd0;
            tx_q            <= 2'd0;
            ty_q            <= 2'd0;
            data_q          <= 128'h0;
            rgba_q          <= 32'h0000_0000;
            err_q           <= 1'b0;
            busy_q          <= 1'b0;
            mem_req_valid_q <= 1'b0;
            rsp_valid_q     <= 2'b00;
        end else begin
            state_q         <= state_d;
            rr_q            <= rr_d;
            id_q            <= id_d;
            line_q          <= line_d;
            fmt_q           <= fmt_d;
            tx_q            <= tx_d;
            ty_q            <= ty_d;
            data_q          <= data_d;
            rgba_q          <= rgba_d;
            err_q           <= err_d;
            busy_q          <= (state_d != ST_IDLE);
            mem_req_valid_q <= (state_d == ST_MEM_REQ);
            rsp_valid_q     <= (state_d == ST_RESP) ? id_onehot(id_d) : 2'b00;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = {line_q, 4'b0000};
    assign dec_data      = data_q;
    assign dec_format    = fmt_q;
    assign dec_texelX    = tx_q;
    assign dec_texelY    = ty_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rgba      = rgba_q;
    assign rsp_err       = err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_tex_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// tb_tex_fetch_scheduler
//   Self-checking bench for tex_fetch_scheduler. A memory model and a
//   texel-select decoder model sit around the DUT; a scoreboard queue holds
//   the expected result of every granted request.
// ---------------------------------------------------------------------------
module tb_tex_fetch_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [63:0]  req_addr;
    logic [9:0]   req_format;
    logic [3:0]   req_texelX;
    logic [3:0]   req_texelY;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic [127:0] mem_rsp_data;
    logic [127:0] dec_data;
    logic [4:0]   dec_format;
    logic [1:0]   dec_texelX;
    logic [1:0]   dec_texelY;
    logic [31:0]  dec_rgba;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [31:0]  rsp_rgba;
    logic         rsp_err;
    logic         busy;

    always #5 clk = ~clk;

    tex_fetch_scheduler #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_format(req_format), .req_texelX(req_texelX), .req_texelY(req_texelY),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .dec_data(dec_data), .dec_format(dec_format),
        .dec_texelX(dec_texelX), .dec_texelY(dec_texelY), .dec_rgba(dec_rgba),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rgba(rsp_rgba),
        .rsp_err(rsp_err), .busy(busy)
    );

    // Decoder model: pick the 32-bit word addressed by texelX.
    assign dec_rgba = dec_data[{dec_texelX, 5'b00000} +: 32];

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  fmt;
        logic [1:0]  tx;
        logic [1:0]  ty;
    } req_t;

    typedef struct packed {
        logic        id;
        logic [31:0] maddr;
        logic [31:0] rgba;
        logic        err;
        logic        cmp;
    } exp_t;

    req_t rq0[$];
    req_t rq1[$];
    exp_t sb[$];
    logic gnt_log[$];
    logic [127:0] mem_img [logic [31:0]];

    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc = 0;
    int gnt_cyc = 0;
    int last_lat = -1;
    bit lat_pending = 1'b0;
    int mem_pulses = 0;
    int rsp_count = 0;
    int hold_checks = 0;
    int mem_ready_delay = 0;
    int rsp_ready_delay = 0;
    int mem_wait_cnt = 0;
    int rsp_wait_cnt = 0;
    bit mem_hs_seen = 1'b0;
    logic [31:0] mem_hs_addr = 32'h0;
    bit rsp_suppress = 1'b0;
    bit stray_rsp = 1'b0;
    bit mreq_hold = 1'b0;
    logic [31:0] prev_maddr = 32'h0;
    bit rsp_hold = 1'b0;
    logic [1:0] prev_rv = 2'b00;
    logic [31:0] prev_rgba = 32'h0;
    logic prev_err = 1'b0;

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    function automatic req_t mk_req(input logic [31:0] a, input logic [4:0] f,
                                    input logic [1:0] x, input logic [1:0] y);
        req_t r;
        r.addr = a; r.fmt = f; r.tx = x; r.ty = y;
        return r;
    endfunction

    function automatic logic [127:0] line_data(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return {a ^ 32'hC3C3_0303, a ^ 32'h3C3C_0202, a ^ 32'h9999_0101, a ^ 32'h6666_0000};
    endfunction

    // Expected outcome of a request, computed from the request alone.
    function automatic exp_t expect_for(input req_t r, input logic id);
        exp_t e;
        logic [127:0] ld;
        e.id    = id;
        e.maddr = {r.addr[31:4], 4'h0};
        if (r.fmt[1:0] == 2'b10) begin
            e.rgba = 32'h0; e.err = 1'b1; e.cmp = 1'b1;
        end else begin
            ld = line_data(e.maddr);
            e.rgba = ld[{r.tx, 5'b00000} +: 32]; e.err = 1'b0; e.cmp = 1'b0;
        end
        return e;
    endfunction

    // Drive all DUT inputs for the coming cycle (called just after posedge).
    task automatic drive();
        req_valid  = {rq1.size() != 0, rq0.size() != 0};
        req_addr   = {rq1.size() ? rq1[0].addr : 32'h0, rq0.size() ? rq0[0].addr : 32'h0};
        req_format = {rq1.size() ? rq1[0].fmt : 5'd0, rq0.size() ? rq0[0].fmt : 5'd0};
        req_texelX = {rq1.size() ? rq1[0].tx : 2'd0, rq0.size() ? rq0[0].tx : 2'd0};
        req_texelY = {rq1.size() ? rq1[0].ty : 2'd0, rq0.size() ? rq0[0].ty : 2'd0};
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 128'h0;
        if (mem_hs_seen) begin
            mem_hs_seen = 1'b0;
            if (!rsp_suppress) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = line_data(mem_hs_addr);
            end
        end
        if (stray_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = {4{32'hDEAD_BEEF}};
            stray_rsp     = 1'b0;
        end
        mem_req_ready = 1'b0;
        if (rst_n && mem_req_valid) begin
            if (mem_wait_cnt >= mem_ready_delay) mem_req_ready = 1'b1;
            else mem_wait_cnt++;
        end
        rsp_ready = 2'b00;
        if (rst_n && rsp_valid != 2'b00) begin
            if (rsp_wait_cnt >= rsp_ready_delay) begin
                rsp_ready = 2'b11;
            end else begin
                rsp_ready = ~rsp_valid;   // only the non-owner says ready
                rsp_wait_cnt++;
            end
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    task automatic sample_outputs();
        logic [1:0] gnt;
        req_t r;
        exp_t e;
        chk_cnt++;
        if (((req_ready & (req_ready - 2'b01)) !== 2'b00) || (busy === 1'b1 && req_ready !== 2'b00)
            || ((req_ready & ~req_valid) !== 2'b00))
            $display("FAIL req_ready_legal: got req_ready=%b (busy=%b req_valid=%b) expected one-hot granted in idle",
                     req_ready, busy, req_valid);
        else pass_cnt++;
        if (mreq_hold) begin
            chk_cnt++; hold_checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== prev_maddr)
                $display("FAIL mem_req_stable: got valid=%b addr=%h expected valid=1 addr=%h",
                         mem_req_valid, mem_req_addr, prev_maddr);
            else pass_cnt++;
        end
        if (rsp_hold) begin
            chk_cnt++; hold_checks++;
            if (rsp_valid !== prev_rv || rsp_rgba !== prev_rgba || rsp_err !== prev_err)
                $display("FAIL rsp_stable: got v=%b rgba=%h err=%b expected v=%b rgba=%h err=%b",
                         rsp_valid, rsp_rgba, rsp_err, prev_rv, prev_rgba, prev_err);
            else pass_cnt++;
        end
        if (lat_pending && rsp_valid !== 2'b00) begin
            last_lat = cyc - gnt_cyc;
            lat_pending = 1'b0;
        end
        gnt = req_ready & req_valid;
        if (gnt == 2'b01) begin
            r = rq0.pop_front();
            sb.push_back(expect_for(r, 1'b0));
            gnt_log.push_back(1'b0);
            gnt_cyc = cyc; lat_pending = 1'b1;
        end else if (gnt == 2'b10) begin
            r = rq1.pop_front();
            sb.push_back(expect_for(r, 1'b1));
            gnt_log.push_back(1'b1);
            gnt_cyc = cyc; lat_pending = 1'b1;
        end
        if (mem_req_valid === 1'b1) begin
            chk_cnt++;
            if (sb.size() == 0 || sb[0].cmp)
                $display("FAIL mem_req_unexpected: got mem_req_valid=1 expected 0");
            else if (mem_req_addr !== sb[0].maddr)
                $display("FAIL mem_req_addr: got %h expected %h", mem_req_addr, sb[0].maddr);
            else pass_cnt++;
            if (mem_req_ready) begin
                mem_hs_seen = 1'b1; mem_hs_addr = mem_req_addr;
                mem_wait_cnt = 0; mem_pulses++;
            end
        end
        if (rsp_valid !== 2'b00) begin
            if (sb.size() == 0) begin
                chk_cnt++;
                $display("FAIL rsp_unexpected: got rsp_valid=%b expected 00", rsp_valid);
            end else if ((rsp_valid & rsp_ready) != 2'b00) begin
                e = sb.pop_front();
                chk_cnt++;
                if (rsp_valid !== onehot(e.id) || rsp_rgba !== e.rgba || rsp_err !== e.err)
                    $display("FAIL rsp_result: got v=%b rgba=%h err=%b expected v=%b rgba=%h err=%b",
                             rsp_valid, rsp_rgba, rsp_err, onehot(e.id), e.rgba, e.err);
                else pass_cnt++;
                rsp_count++;
                rsp_wait_cnt = 0;
            end
        end
        mreq_hold  = (mem_req_valid === 1'b1) && (mem_req_ready !== 1'b1);
        prev_maddr = mem_req_addr;
        rsp_hold   = (rsp_valid !== 2'b00) && ((rsp_valid & rsp_ready) == 2'b00);
        prev_rv = rsp_valid; prev_rgba = rsp_rgba; prev_err = rsp_err;
    endtask

    task automatic tick();
        @(negedge clk);
        sample_outputs();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic reset_assert();
        rst_n = 1'b0;
        #1;
        sb.delete();
        mreq_hold = 1'b0; rsp_hold = 1'b0; lat_pending = 1'b0;
        mem_hs_seen = 1'b0; mem_wait_cnt = 0; rsp_wait_cnt = 0;
        drive();
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();
    endtask

    task automatic run_until_done(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || rq0.size() != 0 || rq1.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (n >= budget) $display("FAIL %s_timeout: got %0d cycles expected completion", name, n);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rq0.push_back(mk_req(32'h0000_0040, 5'd0, 2'd0, 2'd0));
        rq1.push_back(mk_req(32'h0000_0080, 5'd0, 2'd0, 2'd0));
        reset_assert();
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (req_ready !== 2'b00 || mem_req_valid !== 1'b0 || rsp_valid !== 2'b00 || busy !== 1'b0)
            $display("FAIL reset_ctrl: got rr=%b mv=%b rv=%b busy=%b expected all 0",
                     req_ready, mem_req_valid, rsp_valid, busy);
        else pass_cnt++;
        chk_cnt++;
        if (rsp_rgba !== 32'h0 || rsp_err !== 1'b0 || mem_req_addr !== 32'h0)
            $display("FAIL reset_data: got rgba=%h err=%b maddr=%h expected 0", rsp_rgba, rsp_err, mem_req_addr);
        else pass_cnt++;
        chk_cnt++;
        if (dec_data !== 128'h0 || dec_format !== 5'd0 || dec_texelX !== 2'd0 || dec_texelY !== 2'd0)
            $display("FAIL reset_dec: got data=%h fmt=%h x=%h y=%h expected 0",
                     dec_data, dec_format, dec_texelX, dec_texelY);
        else pass_cnt++;
        rq0.delete(); rq1.delete();
        drive();
        reset_release();
    endtask

    task automatic test_single();
        int p0 = mem_pulses;
        int r0 = rsp_count;
        mem_img[32'h0000_1230] = {96'h0123_4567_89AB_CDEF_0F1E_2D3C, 32'h8040_2010};
        rq0.push_back(mk_req(32'h0000_1234, 5'b00100, 2'd0, 2'd0));
        run_until_done(50, "single");
        chk_cnt++;
        if (last_lat !== 4) $display("FAIL single_latency: got %0d expected 4", last_lat);
        else pass_cnt++;
        chk_cnt++;
        if (mem_pulses !== p0 + 1 || mem_hs_addr !== 32'h0000_1230)
            $display("FAIL single_mem: got pulses=%0d addr=%h expected %0d addr=00001230",
                     mem_pulses - p0, mem_hs_addr, 1);
        else pass_cnt++;
        chk_cnt++;
        if (rsp_count !== r0 + 1 || rsp_rgba !== 32'h8040_2010 || rsp_err !== 1'b0)
            $display("FAIL single_rsp: got n=%0d rgba=%h err=%b expected n=1 rgba=80402010 err=0",
                     rsp_count - r0, rsp_rgba, rsp_err);
        else pass_cnt++;
    endtask

    task automatic test_contention();
        reset_assert();
        rq0.push_back(mk_req(32'h0000_1000, 5'b00000, 2'd1, 2'd0));
        rq1.push_back(mk_req(32'h0000_2008, 5'b00001, 2'd2, 2'd1));
        rq0.push_back(mk_req(32'h0000_3010, 5'b10011, 2'd3, 2'd2));
        rq1.push_back(mk_req(32'h0ABC_DEF0, 5'b11100, 2'd0, 2'd3));
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if (req_ready !== 2'b00) $display("FAIL contention_reset_ready: got %b expected 00", req_ready);
        else pass_cnt++;
        gnt_log.delete();
        reset_release();
        run_until_done(100, "contention");
        chk_cnt++;
        if (gnt_log.size() != 4) $display("FAIL contention_count: got %0d expected 4", gnt_log.size());
        else pass_cnt++;
        for (int i = 0; i < gnt_log.size(); i++) begin
            chk_cnt++;
            if (gnt_log[i] !== i[0]) $display("FAIL contention_order[%0d]: got %0d expected %0d", i, gnt_log[i], i[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_compressed();
        int p0 = mem_pulses;
        rq1.push_back(mk_req(32'h0000_5550, 5'b00010, 2'd1, 2'd2));
        run_until_done(20, "compressed");
        chk_cnt++;
        if (last_lat !== 1) $display("FAIL compressed_latency: got %0d expected 1", last_lat);
        else pass_cnt++;
        chk_cnt++;
        if (mem_pulses !== p0) $display("FAIL compressed_no_mem: got %0d reads expected 0", mem_pulses - p0);
        else pass_cnt++;
        chk_cnt++;
        if (rsp_rgba !== 32'h0 || rsp_err !== 1'b1)
            $display("FAIL compressed_rsp: got rgba=%h err=%b expected 00000000 1", rsp_rgba, rsp_err);
        else pass_cnt++;
        // format[1:0]==11 is supported; upper format bits do not matter.
        rq1.push_back(mk_req(32'h0000_7770, 5'b11110, 2'd0, 2'd0));
        rq1.push_back(mk_req(32'h0000_8884, 5'b00011, 2'd2, 2'd1));
        run_until_done(40, "compressed_mix");
        chk_cnt++;
        if (mem_pulses !== p0 + 1) $display("FAIL compressed_mix_mem: got %0d reads expected 1", mem_pulses - p0);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int h0 = hold_checks;
        int r0 = rsp_count;
        mem_ready_delay = 5;
        rsp_ready_delay = 3;
        rq0.push_back(mk_req(32'hCAFE_BAB8, 5'b00101, 2'd3, 2'd1));
        run_until_done(60, "backpressure");
        chk_cnt++;
        if (last_lat !== 9) $display("FAIL bp_latency: got %0d expected 9", last_lat);
        else pass_cnt++;
        chk_cnt++;
        if (hold_checks - h0 !== 8) $display("FAIL bp_hold_cycles: got %0d expected 8", hold_checks - h0);
        else pass_cnt++;
        chk_cnt++;
        if (rsp_count - r0 !== 1) $display("FAIL bp_count: got %0d expected 1", rsp_count - r0);
        else pass_cnt++;
        mem_ready_delay = 0;
        rsp_ready_delay = 0;
    endtask

    task automatic test_stray_reset();
        logic [127:0] d0;
        int p0;
        int r0;
        int n;
        d0 = dec_data;
        stray_rsp = 1'b1;
        repeat (3) tick();
        chk_cnt++;
        if (busy !== 1'b0 || dec_data !== d0)
            $display("FAIL stray_idle: got busy=%b data=%h expected busy=0 data=%h", busy, dec_data, d0);
        else pass_cnt++;
        p0 = mem_pulses;
        rsp_suppress = 1'b1;
        rq0.push_back(mk_req(32'h0000_9990, 5'b00000, 2'd1, 2'd1));
        n = 0;
        while (mem_pulses == p0 && n < 20) begin tick(); n++; end
        chk_cnt++;
        if (mem_pulses == p0) $display("FAIL midreset_reach_wait: got %0d reads expected 1", mem_pulses - p0);
        else pass_cnt++;
        #2;
        r0 = rsp_count;
        reset_assert();
        chk_cnt++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00 || mem_req_valid !== 1'b0)
            $display("FAIL midreset_async: got busy=%b rv=%b mv=%b expected 0", busy, rsp_valid, mem_req_valid);
        else pass_cnt++;
        rq0.delete(); rq1.delete();
        rsp_suppress = 1'b0;
        stray_rsp = 1'b1;
        reset_release();
        repeat (6) tick();
        chk_cnt++;
        if (busy !== 1'b0 || rsp_count !== r0 || dec_data !== 128'h0)
            $display("FAIL midreset_after: got busy=%b rsps=%0d data=%h expected busy=0 rsps=0 data=0",
                     busy, rsp_count - r0, dec_data);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int r0 = rsp_count;
        gnt_log.delete();
        for (int i = 0; i < 6; i++) begin
            req_t r;
            r = mk_req($urandom, 5'($urandom_range(31, 0)), 2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)));
            if (i % 2 == 0) rq0.push_back(r);
            else rq1.push_back(r);
        end
        run_until_done(200, "back_to_back");
        chk_cnt++;
        if (rsp_count - r0 !== 6) $display("FAIL b2b_count: got %0d expected 6", rsp_count - r0);
        else pass_cnt++;
        for (int i = 1; i < gnt_log.size(); i++) begin
            chk_cnt++;
            if (gnt_log[i] === gnt_log[i-1])
                $display("FAIL b2b_alternate[%0d]: got %0d expected %0d", i, gnt_log[i], ~gnt_log[i-1]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 2'b00; req_addr = 64'h0; req_format = 10'h0;
        req_texelX = 4'h0; req_texelY = 4'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 128'h0;
        rsp_ready = 2'b00;
        test_reset();
        test_single();
        test_contention();
        test_compressed();
        test_backpressure();
        test_stray_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
